// File: rtl/vga_if.sv
// VGA raster bus shared by the timing generator and every draw stage.
// The source drives it through modport out; a consuming stage uses modport in.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source for the draw pipeline: counters, sync/blank decode on a
// black background, and a one-cycle tick at the start of every frame.
module vga_timing_gen #(
  parameter int   HOR_PIXELS     = 1024,
  parameter int   HOR_TOTAL      = 1344,
  parameter int   HOR_SYNC_START = 1048,
  parameter int   HOR_SYNC_WIDTH = 136,
  parameter int   VER_PIXELS     = 768,
  parameter int   VER_TOTAL      = 806,
  parameter int   VER_SYNC_START = 771,
  parameter int   VER_SYNC_WIDTH = 6,
  parameter logic SYNC_ACTIVE    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   out,
  output logic frame_tick
);

  localparam logic [10:0] H_LAST  = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] H_PIX   = 11'(HOR_PIXELS);
  localparam logic [10:0] H_SS    = 11'(HOR_SYNC_START);
  localparam logic [11:0] H_SE    = 12'(HOR_SYNC_START + HOR_SYNC_WIDTH);
  localparam logic [10:0] V_LAST  = 11'(VER_TOTAL - 1);
  localparam logic [10:0] V_PIX   = 11'(VER_PIXELS);
  localparam logic [10:0] V_SS    = 11'(VER_SYNC_START);
  localparam logic [11:0] V_SE    = 12'(VER_SYNC_START + VER_SYNC_WIDTH);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_tick_q, frame_tick_d;
  logic        h_wrap;
  logic        v_wrap;

  // Flags decode the next-state counts so they land in the same cycle as the
  // counts they describe.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d      = (hcount_d >= H_PIX) && (hcount_d <= H_LAST);
    vblnk_d      = (vcount_d >= V_PIX) && (vcount_d <= V_LAST);
    hsync_d      = ((hcount_d >= H_SS) && ({1'b0, hcount_d} < H_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d      = ((vcount_d >= V_SS) && ({1'b0, vcount_d} < V_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_tick_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q     <= 11'd0;
      vcount_q     <= 11'd0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      hblnk_q      <= hblnk_d;
      vblnk_q      <= vblnk_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  // Black background; draw stages overlay their pixels on top.
  assign out.rgb    = 12'h000;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and two
// reduced-size instances (both sync polarities) for frame timing and ticks.
module tb_vga_timing_gen;

  localparam int S_HP  = 16;
  localparam int S_HT  = 24;
  localparam int S_HSS = 18;
  localparam int S_HSW = 3;
  localparam int S_VP  = 8;
  localparam int S_VT  = 12;
  localparam int S_VSS = 9;
  localparam int S_VSW = 2;
  localparam int S_FRAME = S_HT * S_VT;          // 288 clocks
  localparam int K_A     = 9 * S_FRAME + 130;    // lands small raster on h=10, v=5

  logic clk;
  logic rst;
  logic tick_d, tick_s, tick_p;
  int   tests_run;
  int   tests_failed;

  vga_if bus_d ();
  vga_if bus_s ();
  vga_if bus_p ();

  vga_timing_gen dut_d (
    .clk        (clk),
    .rst        (rst),
    .out        (bus_d),
    .frame_tick (tick_d)
  );

  vga_timing_gen #(
    .HOR_PIXELS(S_HP), .HOR_TOTAL(S_HT), .HOR_SYNC_START(S_HSS), .HOR_SYNC_WIDTH(S_HSW),
    .VER_PIXELS(S_VP), .VER_TOTAL(S_VT), .VER_SYNC_START(S_VSS), .VER_SYNC_WIDTH(S_VSW),
    .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .out        (bus_s),
    .frame_tick (tick_s)
  );

  vga_timing_gen #(
    .HOR_PIXELS(S_HP), .HOR_TOTAL(S_HT), .HOR_SYNC_START(S_HSS), .HOR_SYNC_WIDTH(S_HSW),
    .VER_PIXELS(S_VP), .VER_TOTAL(S_VT), .VER_SYNC_START(S_VSS), .VER_SYNC_WIDTH(S_VSW),
    .SYNC_ACTIVE(1'b0)
  ) dut_p (
    .clk        (clk),
    .rst        (rst),
    .out        (bus_p),
    .frame_tick (tick_p)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [38:0] obs_d, obs_s, obs_p;
  assign obs_d = {bus_d.hcount, bus_d.vcount, bus_d.hsync, bus_d.vsync, bus_d.hblnk, bus_d.vblnk, bus_d.rgb, tick_d};
  assign obs_s = {bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.vsync, bus_s.hblnk, bus_s.vblnk, bus_s.rgb, tick_s};
  assign obs_p = {bus_p.hcount, bus_p.vcount, bus_p.hsync, bus_p.vsync, bus_p.hblnk, bus_p.vblnk, bus_p.rgb, tick_p};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Closed-form raster: k edges after reset release (k=0 is the reset state).
  function automatic logic [38:0] model(input int k, input int hp, input int ht, input int hss,
                                        input int hsw, input int vp, input int vt, input int vss,
                                        input int vsw, input logic act);
    int   h, v;
    logic hs, vs, hb, vb, tk;
    h  = k % ht;
    v  = (k / ht) % vt;
    hb = (h >= hp);
    vb = (v >= vp);
    hs = (h >= hss && h < hss + hsw) ? act : ~act;
    vs = (v >= vss && v < vss + vsw) ? act : ~act;
    tk = (k > 0) && (k % (ht * vt) == 0);
    return {11'(h), 11'(v), hs, vs, hb, vb, 12'h000, tk};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int k);
    check($sformatf("d_raster k=%0d", k), 64'(obs_d),
          64'(model(k, 1024, 1344, 1048, 136, 768, 806, 771, 6, 1'b1)));
    check($sformatf("s_raster k=%0d", k), 64'(obs_s),
          64'(model(k, S_HP, S_HT, S_HSS, S_HSW, S_VP, S_VT, S_VSS, S_VSW, 1'b1)));
    check($sformatf("p_raster k=%0d", k), 64'(obs_p),
          64'(model(k, S_HP, S_HT, S_HSS, S_HSW, S_VP, S_VT, S_VSS, S_VSW, 1'b0)));
  endtask

  initial begin
    int last_tick;
    int n_ticks;
    int hs_hi_d;
    int vs_hi_s;
    int vs_lo_p;
    int vb_hi_s;
    logic [10:0] prev_h_d, prev_v_d;
    logic        prev_hb_d;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    repeat (5) step();

    // reset state
    check_all(0);
    check("d_rst_hsync", 64'(bus_d.hsync), 64'd0);
    check("d_rst_vsync", 64'(bus_d.vsync), 64'd0);
    check("p_rst_hsync_idle", 64'(bus_p.hsync), 64'd1);
    check("p_rst_vsync_idle", 64'(bus_p.vsync), 64'd1);
    check("d_rst_tick", 64'(tick_d), 64'd0);

    rst       = 1'b0;
    last_tick = -1;
    n_ticks   = 0;
    hs_hi_d   = 0;
    vs_hi_s   = 0;
    vs_lo_p   = 0;
    vb_hi_s   = 0;
    prev_h_d  = bus_d.hcount;
    prev_v_d  = bus_d.vcount;
    prev_hb_d = bus_d.hblnk;

    for (int k = 1; k <= K_A; k++) begin
      step();
      check_all(k);
      if (k == 1) check("d_first_hcount", 64'(bus_d.hcount), 64'd1);
      if (k <= 1344 && bus_d.hsync) hs_hi_d++;
      if (k <= S_FRAME) begin
        if (bus_s.vsync) vs_hi_s++;
        if (!bus_p.vsync) vs_lo_p++;
        if (bus_s.vblnk) vb_hi_s++;
      end
      if (bus_d.hblnk && !prev_hb_d) check("d_hblnk_rise_h", 64'(bus_d.hcount), 64'd1024);
      if (!bus_d.hblnk && prev_hb_d) check("d_hblnk_fall_h", 64'(bus_d.hcount), 64'd0);
      if (bus_d.vcount != prev_v_d) begin
        check("d_vinc_prev_h", 64'(prev_h_d), 64'd1343);
        check("d_vinc_h", 64'(bus_d.hcount), 64'd0);
        check("d_vinc_step", 64'(bus_d.vcount), 64'(prev_v_d + 11'd1));
      end
      if (tick_s) begin
        n_ticks++;
        if (last_tick < 0) check("s_first_tick_k", 64'(k), 64'(S_FRAME));
        else check("s_tick_gap", 64'(k - last_tick), 64'(S_FRAME));
        last_tick = k;
      end
      prev_h_d  = bus_d.hcount;
      prev_v_d  = bus_d.vcount;
      prev_hb_d = bus_d.hblnk;
    end

    check("d_hsync_width", 64'(hs_hi_d), 64'd136);
    check("s_vsync_clocks", 64'(vs_hi_s), 64'(S_VSW * S_HT));
    check("p_vsync_low_clocks", 64'(vs_lo_p), 64'(S_VSW * S_HT));
    check("s_vblnk_clocks", 64'(vb_hi_s), 64'((S_VT - S_VP) * S_HT));
    check("s_tick_count", 64'(n_ticks), 64'd9);
    check("s_pos_h_before_rst", 64'(bus_s.hcount), 64'd10);
    check("s_pos_v_before_rst", 64'(bus_s.vcount), 64'd5);
    check("d_pos_h_before_rst", 64'(bus_d.hcount), 64'd34);
    check("d_pos_v_before_rst", 64'(bus_d.vcount), 64'd2);

    // mid-frame reset for one edge
    rst = 1'b1;
    step();
    check_all(0);
    check("s_midrst_tick", 64'(tick_s), 64'd0);
    rst       = 1'b0;
    last_tick = -1;
    n_ticks   = 0;
    for (int k = 1; k <= S_FRAME + 20; k++) begin
      step();
      check_all(k);
      if (tick_s) begin
        n_ticks++;
        check("s_tick_after_midrst_k", 64'(k), 64'(S_FRAME));
      end
    end
    check("s_tick_count_after_midrst", 64'(n_ticks), 64'd1);
    check("d_hcount_after_midrst", 64'(bus_d.hcount), 64'(S_FRAME + 20));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_if bus. Generates the hcount/vcount/hsync/vsync/hblnk/vblnk raster that every draw_* stage consumes and re-registers.
- Sits at the head of the draw pipeline, in the 65 MHz pixel clock domain, and targets 1024x768 at 60 Hz.
- Drives rgb to zero (black background), so the first draw stage overlays on black.
- Also emits a one-cycle frame tick for game/physics logic that updates keeper and ball positions once per frame.

Parameters:
- HOR_PIXELS, 1024, visible pixels per line
- HOR_TOTAL, 1344, clocks per line
- HOR_SYNC_START, 1048, first hcount with hsync asserted
- HOR_SYNC_WIDTH, 136, hsync length in clocks
- VER_PIXELS, 768, visible lines per frame
- VER_TOTAL, 806, lines per frame
- VER_SYNC_START, 771, first vcount with vsync asserted
- VER_SYNC_WIDTH, 6, vsync length in lines
- SYNC_ACTIVE, 1'b1, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- out  vga_if.out  -  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_tick  out  1  one-cycle pulse at the start of each frame (after wrap)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, on rst. All outputs are registered (flip-flop outputs, no combinational path to ports).
- Reset values: hcount=0, vcount=0, hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE, hblnk=0, vblnk=0, rgb=0, frame_tick=0.
- rst asserted mid-frame: on the next edge all outputs return to their reset values. Counting resumes from 0,0 on the first edge with rst low.
- Horizontal counter:
  - Increments by 1 every clock.
  - At HOR_TOTAL-1 it wraps to 0 on the next edge.
  - Never exceeds HOR_TOTAL-1.
- Vertical counter:
  - Increments only on the edge where hcount wraps (HOR_TOTAL-1 -> 0).
  - At VER_TOTAL-1, coincident with the hcount wrap, it wraps to 0.
  - Holds its value otherwise.
- Decode:
  - Computed from the next-state counter values and registered, so the flags are cycle-aligned with the hcount/vcount on the bus. No extra latency between count and flags.
  - hblnk = 1 when HOR_PIXELS <= hcount <= HOR_TOTAL-1.
  - vblnk = 1 when VER_PIXELS <= vcount <= VER_TOTAL-1.
  - hsync = SYNC_ACTIVE when HOR_SYNC_START <= hcount < HOR_SYNC_START+HOR_SYNC_WIDTH, else ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when VER_SYNC_START <= vcount < VER_SYNC_START+VER_SYNC_WIDTH. The test is on vcount only: vsync changes on the hcount=0 cycle of the line.
- rgb: constant 12'h000 at all times.
- frame_tick:
  - Asserted for exactly one cycle, the cycle in which the bus shows hcount=0, vcount=0 reached by a wrap from (HOR_TOTAL-1, VER_TOTAL-1).
  - Not asserted in the first cycle after reset release. The first pulse comes one full frame later.
- Widths: counters are 11 bits. The parameter defaults must satisfy HOR_TOTAL <= 2048 and VER_TOTAL <= 2048. Comparisons are unsigned.
- Parameter consistency is a static design rule:
  - HOR_PIXELS < HOR_SYNC_START
  - HOR_SYNC_START+HOR_SYNC_WIDTH <= HOR_TOTAL
  - the same ordering holds for the vertical parameters
  - Behaviour for violating parameter sets is undefined.
- Frame period: HOR_TOTAL*VER_TOTAL = 1,083,264 clocks at the defaults.

Test Plan:
- Reset release: hold rst 5 cycles, then drop it.
  - During rst: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=0, tick=0.
  - First edge after release: hcount=1.
- Line timing:
  - hblnk rises when hcount=1024 and falls when hcount=0.
  - hsync is 1 for hcount 1048..1183 (136 cycles).
  - vcount increments exactly when hcount goes 1343 -> 0.
- Frame timing:
  - vblnk is 1 for vcount 768..805.
  - vsync is 1 for vcount 771..776 (6 lines = 8064 clocks).
  - vcount goes 805 -> 0 coincident with hcount 1343 -> 0.
- frame_tick:
  - No pulse in the first frame after reset.
  - Pulse exactly 1 cycle wide at each (0,0) after a wrap.
  - Successive pulses are exactly 1,083,264 cycles apart over 3 frames.
- Mid-frame reset: assert rst at hcount=500, vcount=400 for 1 cycle.
  - Next cycle: all outputs at reset values.
  - Counting restarts at 0,0.
  - Next tick comes 1,083,264 cycles after release.
- Polarity override: SYNC_ACTIVE=0.
  - hsync/vsync idle at 1 and go to 0 in the same windows as above.
  - Blanking and counts are unchanged.
